// File: rtl/alu_mdu_pkg.sv
// Shared definitions for alu_mdu: op-code encodings, FSM state type and op-class decode helpers.
// MUL-class ops occupy 5'b100xx and DIV-class ops 5'b101xx; every other code is single-cycle.
package alu_mdu_pkg;

    localparam logic [4:0] OP_NOP    = 5'd0;
    localparam logic [4:0] OP_LUI    = 5'd1;
    localparam logic [4:0] OP_AUIPC  = 5'd2;
    localparam logic [4:0] OP_ADD    = 5'd3;
    localparam logic [4:0] OP_SUB    = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_OR     = 5'd6;
    localparam logic [4:0] OP_AND    = 5'd7;
    localparam logic [4:0] OP_SLL    = 5'd8;
    localparam logic [4:0] OP_SRL    = 5'd9;
    localparam logic [4:0] OP_SRA    = 5'd10;
    localparam logic [4:0] OP_SLT    = 5'd11;
    localparam logic [4:0] OP_SLTU   = 5'd12;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_mul_op(input logic [4:0] o);
        return (o[4:2] == 3'b100);
    endfunction

    function automatic logic is_div_op(input logic [4:0] o);
        return (o[4:2] == 3'b101);
    endfunction

    function automatic logic is_signed_div_op(input logic [4:0] o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] o);
        return (o == OP_REM) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_mdu_div.sv
// Iterative restoring divider on unsigned magnitudes; one quotient bit per cycle over WIDTH cycles.
// quotient/remainder present the final values during the cycle in which done is high.
module alu_mdu_div
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

    logic             active_r;
    logic [SW-1:0]    cnt_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] quo_nxt_s;
    logic [WIDTH-1:0] rem_nxt_s;

    // one restoring step: trial-subtract the divisor from the shifted partial remainder
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, dvs_r};
        if (diff_s[WIDTH] == 1'b0) begin
            rem_nxt_s = diff_s[WIDTH-1:0];
        end else begin
            rem_nxt_s = shifted_s[WIDTH-1:0];
        end
        quo_nxt_s = {quo_r[WIDTH-2:0], ~diff_s[WIDTH]};
    end

    assign done      = active_r && (cnt_r == CNT_LAST);
    assign quotient  = quo_nxt_s;
    assign remainder = rem_nxt_s;

    // iteration state: load on start, step while active, drop on abort or final step
    always_ff @(posedge clk) begin
        if (rst) begin
            active_r <= 1'b0;
            cnt_r    <= {SW{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            dvs_r    <= {WIDTH{1'b0}};
        end else if (abort) begin
            active_r <= 1'b0;
            cnt_r    <= {SW{1'b0}};
        end else if (start) begin
            active_r <= 1'b1;
            cnt_r    <= {SW{1'b0}};
            quo_r    <= dividend;
            rem_r    <= {WIDTH{1'b0}};
            dvs_r    <= divisor;
        end else if (active_r) begin
            quo_r    <= quo_nxt_s;
            rem_r    <= rem_nxt_s;
            cnt_r    <= cnt_r + SW'(1);
            active_r <= !done;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// ALU with iterative multiplier and optional iterative divider behind a valid/ready handshake.
// Define ALU_MDU_DIV_EN to build the divider; without it DIV-class ops return 0 after one cycle.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

    state_e             state_r;
    state_e             state_s;
    state_e             tgt_s;
    logic [4:0]         op_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   mcand_r;
    logic               neg_r;
    logic [SW-1:0]      cnt_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_s;
    logic               result_load_s;
    logic               accept_s;
    logic [SW-1:0]      shamt_s;
    logic [WIDTH-1:0]   alu_s;
    logic               m_a_neg_s;
    logic               m_b_neg_s;
    logic [WIDTH-1:0]   m_a_mag_s;
    logic [WIDTH-1:0]   m_b_mag_s;
    logic [WIDTH:0]     m_sum_s;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   mul_res_s;
    logic               neg_ld_s;
    logic [WIDTH-1:0]   div_fast_s;
    logic               div_long_s;
    logic               div_neg_s;
    logic               div_done_s;
    logic [WIDTH-1:0]   div_res_s;

    assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s  = in_valid && in_ready && !kill;
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r == ST_MUL) || (state_r == ST_DIV);
    assign result    = result_r;
    assign zero      = (result_r == {WIDTH{1'b0}});
    assign shamt_s   = b[SW-1:0];

    // single-cycle operations; unknown codes fall through as NOP
    always_comb begin
        alu_s = a;
        case (op)
            OP_NOP:   alu_s = a;
            OP_LUI:   alu_s = b;
            OP_AUIPC: alu_s = pc + b;
            OP_ADD:   alu_s = a + b;
            OP_SUB:   alu_s = a - b;
            OP_XOR:   alu_s = a ^ b;
            OP_OR:    alu_s = a | b;
            OP_AND:   alu_s = a & b;
            OP_SLL:   alu_s = a << shamt_s;
            OP_SRL:   alu_s = a >> shamt_s;
            OP_SRA:   alu_s = $signed(a) >>> shamt_s;
            OP_SLT:   alu_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  alu_s = {{(WIDTH-1){1'b0}}, (a < b)};
            default:  alu_s = a;
        endcase
    end

    // multiplier works on magnitudes; the sign of the full product is restored at the end
    assign m_a_neg_s = a[WIDTH-1] && ((op == OP_MULH) || (op == OP_MULHSU));
    assign m_b_neg_s = b[WIDTH-1] && (op == OP_MULH);
    assign m_a_mag_s = m_a_neg_s ? -a : a;
    assign m_b_mag_s = m_b_neg_s ? -b : b;
    assign m_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                     + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    assign acc_nxt_s = {m_sum_s, acc_r[WIDTH-1:1]};
    assign prod_s    = neg_r ? -acc_nxt_s : acc_nxt_s;
    assign mul_res_s = (op_r == OP_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];

`ifdef ALU_MDU_DIV_EN
    logic             d_signed_s;
    logic             d_a_neg_s;
    logic             d_b_neg_s;
    logic             d_zero_s;
    logic             d_ovf_s;
    logic [WIDTH-1:0] d_dvd_s;
    logic [WIDTH-1:0] d_dvs_s;
    logic [WIDTH-1:0] d_quo_s;
    logic [WIDTH-1:0] d_rem_s;
    logic [WIDTH-1:0] d_val_s;

    assign d_signed_s = is_signed_div_op(op);
    assign d_a_neg_s  = d_signed_s && a[WIDTH-1];
    assign d_b_neg_s  = d_signed_s && b[WIDTH-1];
    assign d_dvd_s    = d_a_neg_s ? -a : a;
    assign d_dvs_s    = d_b_neg_s ? -b : b;
    assign d_zero_s   = (b == {WIDTH{1'b0}});
    assign d_ovf_s    = d_signed_s && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    // divide-by-zero and signed overflow resolve immediately without iterating
    assign div_fast_s = d_zero_s ? (is_rem_op(op) ? a : {WIDTH{1'b1}})
                                 : (is_rem_op(op) ? {WIDTH{1'b0}} : a);
    assign div_long_s = is_div_op(op) && !d_zero_s && !d_ovf_s;
    assign div_neg_s  = is_rem_op(op) ? d_a_neg_s : (d_a_neg_s ^ d_b_neg_s);

    alu_mdu_div #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .abort     (kill),
        .start     (accept_s && div_long_s),
        .dividend  (d_dvd_s),
        .divisor   (d_dvs_s),
        .done      (div_done_s),
        .quotient  (d_quo_s),
        .remainder (d_rem_s)
    );

    assign d_val_s   = is_rem_op(op_r) ? d_rem_s : d_quo_s;
    assign div_res_s = neg_r ? -d_val_s : d_val_s;
`else
    assign div_fast_s = {WIDTH{1'b0}};
    assign div_long_s = 1'b0;
    assign div_neg_s  = 1'b0;
    assign div_done_s = 1'b0;
    assign div_res_s  = {WIDTH{1'b0}};
`endif

    assign neg_ld_s = is_mul_op(op) ? (m_a_neg_s ^ m_b_neg_s) : div_neg_s;

    // destination state for a newly accepted op
    always_comb begin
        if (is_mul_op(op)) begin
            tgt_s = ST_MUL;
        end else if (div_long_s) begin
            tgt_s = ST_DIV;
        end else begin
            tgt_s = ST_DONE;
        end
    end

    // next-state logic; kill overrides everything except reset
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = tgt_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (div_done_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DIV;
                end
            end
            ST_DONE: begin
                if (!out_ready) begin
                    state_s = ST_DONE;
                end else if (accept_s) begin
                    state_s = tgt_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        if (kill) begin
            state_s = ST_IDLE;
        end else begin
            state_s = state_s;
        end
    end

    // result update: single-cycle ops at acceptance, iterative ops on their final step
    always_comb begin
        result_load_s = 1'b0;
        result_s      = result_r;
        if (accept_s && (tgt_s == ST_DONE)) begin
            result_load_s = 1'b1;
            result_s      = is_div_op(op) ? div_fast_s : alu_s;
        end else if ((state_r == ST_MUL) && (cnt_r == CNT_LAST) && !kill) begin
            result_load_s = 1'b1;
            result_s      = mul_res_s;
        end else if ((state_r == ST_DIV) && div_done_s && !kill) begin
            result_load_s = 1'b1;
            result_s      = div_res_s;
        end else begin
            result_load_s = 1'b0;
        end
    end

    // FSM, operand latch and shift-add multiplier state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_NOP;
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            neg_r    <= 1'b0;
            cnt_r    <= {SW{1'b0}};
            result_r <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                op_r    <= op;
                neg_r   <= neg_ld_s;
                cnt_r   <= {SW{1'b0}};
                acc_r   <= {{WIDTH{1'b0}}, m_b_mag_s};
                mcand_r <= m_a_mag_s;
            end else if (state_r == ST_MUL) begin
                acc_r <= acc_nxt_s;
                cnt_r <= cnt_r + SW'(1);
            end
            if (result_load_s) begin
                result_r <= result_s;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed, table-driven bench for alu_mdu (WIDTH=32); expectations follow ALU_MDU_DIV_EN.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

`ifdef ALU_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_mdu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .pc        (pc),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ipc, input logic [31:0] ex, input int el);
        vecs.push_back('{o, ia, ib, ipc, ex, el});
    endtask

    // issue one op at a negedge, measure latency to out_valid, check, then retire it
    task automatic do_op(input int idx, input vec_t v);
        int lat;
        chk($sformatf("v%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
        op = v.op; a = v.a; b = v.b; pc = v.pc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        if (v.lat > 1) chk($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_result", idx), result, v.exp);
        chk($sformatf("v%0d_zero", idx), {31'd0, zero}, {31'd0, (v.exp == 32'd0)});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk($sformatf("v%0d_retired", idx), {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        op = OP_NOP; a = 32'd0; b = 32'd0; pc = 32'd0;

        add(OP_ADD,    32'h7FFFFFFF, 32'h00000001, 32'd0, 32'h80000000, 1);
        add(OP_SUB,    32'd5,        32'd7,        32'd0, 32'hFFFFFFFE, 1);
        add(OP_XOR,    32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'hFF00FF00, 1);
        add(OP_OR,     32'h12340000, 32'h00005678, 32'd0, 32'h12345678, 1);
        add(OP_AND,    32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'h00F000F0, 1);
        add(OP_SLL,    32'h00000001, 32'h00000021, 32'd0, 32'h00000002, 1);
        add(OP_SRL,    32'h80000000, 32'd4,        32'd0, 32'h08000000, 1);
        add(OP_SRA,    32'h80000000, 32'd4,        32'd0, 32'hF8000000, 1);
        add(OP_SLT,    32'hFFFFFFFF, 32'd1,        32'd0, 32'd1,        1);
        add(OP_SLTU,   32'hFFFFFFFF, 32'd1,        32'd0, 32'd0,        1);
        add(OP_LUI,    32'd0,        32'hABCDE000, 32'd0, 32'hABCDE000, 1);
        add(OP_AUIPC,  32'd0,        32'h00000234, 32'h00001000, 32'h00001234, 1);
        add(OP_NOP,    32'hDEADBEEF, 32'd9,        32'd0, 32'hDEADBEEF, 1);
        add(5'd31,     32'hCAFEBABE, 32'd9,        32'd0, 32'hCAFEBABE, 1);
        add(OP_MUL,    32'd6,        32'd7,        32'd0, 32'h0000002A, 33);
        add(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h00000001, 33);
        add(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h00000000, 33);
        add(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 33);
        add(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 33);
        add(OP_MULH,   32'h80000000, 32'h80000000, 32'd0, 32'h40000000, 33);
        add(OP_MULH,   32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 33);
        add(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'd0, DIV_EN ? 32'hFFFFFFFD : 32'd0, DIV_EN ? 33 : 1);
        add(OP_REM,  32'hFFFFFFF9, 32'd2,        32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0, DIV_EN ? 33 : 1);
        add(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd0, DIV_EN ? 32'hFFFFFFFD : 32'd0, DIV_EN ? 33 : 1);
        add(OP_REM,  32'd7,        32'hFFFFFFFE, 32'd0, DIV_EN ? 32'h00000001 : 32'd0, DIV_EN ? 33 : 1);
        add(OP_DIVU, 32'd100,      32'd7,        32'd0, DIV_EN ? 32'd14 : 32'd0,       DIV_EN ? 33 : 1);
        add(OP_REMU, 32'd100,      32'd7,        32'd0, DIV_EN ? 32'd2 : 32'd0,        DIV_EN ? 33 : 1);
        add(OP_DIV,  32'd5,        32'd0,        32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0, 1);
        add(OP_REMU, 32'd5,        32'd0,        32'd0, DIV_EN ? 32'd5 : 32'd0,        1);
        add(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0, DIV_EN ? 32'h80000000 : 32'd0, 1);
        add(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0,                         1);

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result",    result,             32'd0);
        chk("rst_zero",      {31'd0, zero},      32'd1);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(i, vecs[i]);
        end

        // backpressure: hold out_ready low 5 cycles, then retire and accept together
        op = OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_result", i),    result,             32'd3);
            chk($sformatf("bp%0d_in_ready", i),  {31'd0, in_ready},  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1; op = OP_SUB; a = 32'd10; b = 32'd4; in_valid = 1'b1;
        #1;
        chk("bp_retire_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_result",    result,             32'd6);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // reset in the middle of a multiply
        op = OP_MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mrst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_result",    result,             32'd0);
        chk("mrst_zero",      {31'd0, zero},      32'd1);
        chk("mrst_busy",      {31'd0, busy},      32'd0);
        chk("mrst_in_ready",  {31'd0, in_ready},  32'd1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("mrst_no_result", cnt, 32'd0);

        // kill 10 cycles into DIVU, with a same-cycle request that must be ignored
        op = OP_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        if (DIV_EN) begin
            chk("kill_busy_before", {31'd0, busy}, 32'd1);
            chk("kill_no_early",    cnt,           32'd0);
        end
        kill = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("kill_out_valid", {31'd0, out_valid}, 32'd0);
        chk("kill_busy",      {31'd0, busy},      32'd0);
        chk("kill_in_ready",  {31'd0, in_ready},  32'd1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("kill_no_result", cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  5  operation code, encodings from the shared package.
REQ-007 a, b  input  WIDTH  operands, two's complement.
REQ-008 pc  input  WIDTH  instruction address, used only by AUIPC.
REQ-009 kill  input  1  pipeline flush; abandons any operation.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  high when result equals 0.
REQ-014 busy  output  1  high in MUL or DIV state.

Function
REQ-015 Request accepted on a rising edge where in_valid && in_ready && !kill; operands and op latched at acceptance.
REQ-016 in_ready = (state==IDLE) || (state==DONE && out_ready); back-to-back acceptance on the retire cycle supported.
REQ-017 States IDLE, MUL, DIV, DONE; IDLE->MUL on accepted MUL-class op, IDLE->DIV on accepted DIV-class op, IDLE->DONE on any other accepted op.
REQ-018 Single-cycle ops NOP(result=a), LUI(b), AUIPC(pc+b), ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU: out_valid asserted the cycle after acceptance.
REQ-019 Shifts use only b[log2(WIDTH)-1:0] as shift amount; SRA sign-fills from a[WIDTH-1].
REQ-020 SLT signed compare, SLTU unsigned compare; result zero-extended 0/1.
REQ-021 MUL, MULH, MULHSU, MULHU: radix-2 shift-add over exactly WIDTH cycles in MUL, then DONE; MUL returns low WIDTH bits, MULH* return high WIDTH bits of the 2*WIDTH product with signed/signed, signed/unsigned, unsigned/unsigned operands.
REQ-022 DIV, DIVU, REM, REMU: restoring division over exactly WIDTH cycles in DIV, then DONE; signed ops truncate toward zero, remainder takes dividend sign.
REQ-023 Divide by zero: quotient all ones, remainder = a; goes IDLE->DONE directly (latency 1).
REQ-024 Signed overflow (a = most-negative, b = -1): quotient = a, remainder 0; latency 1.
REQ-025 Multi-cycle latency: out_valid asserted WIDTH+1 cycles after acceptance.
REQ-026 DONE holds result and out_valid stable until out_ready; DONE->IDLE on out_ready without new acceptance, DONE->MUL/DIV/DONE on out_ready with acceptance.
REQ-027 kill in any state: next state IDLE, out_valid low next cycle, same-cycle in_valid ignored; kill has priority over out_ready.
REQ-028 Undefined op codes behave as NOP.
REQ-029 zero derived combinationally from registered result.

Reset
REQ-030 rst has priority over kill and all inputs.
REQ-031 After reset: state IDLE, out_valid 0, result 0, zero 1, busy 0, in_ready 1, iteration counter 0.
REQ-032 Reset mid-operation discards partial product/quotient; no result emitted.

Configuration
REQ-033 Macro ALU_MDU_DIV_EN defined: DIV state and divider datapath present per REQ-022..024.
REQ-034 Macro ALU_MDU_DIV_EN undefined: no divider hardware; DIV-class ops complete in 1 cycle with result 0; DIV state unreachable.

Structure
REQ-035 Shared package holds op-code constants, state enum typedef, MUL-class/DIV-class decode helpers.
REQ-036 Sub-module alu_mdu_div holds the iterative divider (start, done, quotient, remainder), instantiated only under ALU_MDU_DIV_EN.

Verification (WIDTH=32)
REQ-037 ADD a=0x7FFFFFFF b=1 -> result 0x80000000, out_valid 1 cycle after accept, zero 0.
REQ-038 MULH a=0xFFFFFFFF b=0xFFFFFFFF -> result 0x00000000, zero 1; MULHU same operands -> 0xFFFFFFFE; out_valid at 33 cycles.
REQ-039 DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV a=5 b=0 -> 0xFFFFFFFF at latency 1; DIV 0x80000000/-1 -> 0x80000000.
REQ-040 out_ready held low 5 cycles in DONE -> result stable, in_ready low; then out_ready high with in_valid high -> new op accepted same cycle.
REQ-041 kill asserted 10 cycles into DIVU -> IDLE next cycle, out_valid never asserted for that op, busy 0.
REQ-042 rst asserted during MUL -> all outputs at REQ-031 values next cycle; build without ALU_MDU_DIV_EN: DIV returns 0 at latency 1.
